// File: rtl/mat_acc_pkg.sv
// Shared types and helpers for the matrix-multiplier stream controller:
// controller state encoding, element-index width and index-to-(row, col) mapping.
package mat_acc_pkg;

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        DRAIN  = 3'd4
    } state_e;

    localparam int unsigned MAT_SIZE_DEF = 2;

    // Width of an element index covering 0..n*n-1 (never narrower than one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    localparam int unsigned IDX_W_DEF = idx_width(MAT_SIZE_DEF);

    // Row-major element index to row number.
    function automatic int unsigned elem_row(input int unsigned idx, input int unsigned n);
        return idx / n;
    endfunction

    // Row-major element index to column number.
    function automatic int unsigned elem_col(input int unsigned idx, input int unsigned n);
        return idx % n;
    endfunction

endpackage

// File: rtl/mat_elem_cnt.sv
// Wrapping element-index counter 0..n_elems-1, shared by the load and drain phases.
module mat_elem_cnt
    import mat_acc_pkg::*;
#(
    parameter int unsigned n_elems = MAT_SIZE_DEF * MAT_SIZE_DEF,
    parameter int unsigned idx_w   = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [idx_w-1:0] idx,
    output logic             last
);
    localparam logic [idx_w-1:0] LAST_IDX = idx_w'(n_elems - 1);

    logic [idx_w-1:0] idx_q, idx_d;

    assign idx  = idx_q;
    assign last = (idx_q == LAST_IDX);

    // Next index: clear wins, otherwise advance and wrap after the last element.
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = last ? '0 : idx_q + 1'b1;
        end
    end

    // Index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/mat_mul_ctrl.sv
// Streaming front-end for the matrix multiplier: assembles A and B from the
// input stream, starts the multiplier, waits for done (with timeout) and
// streams the captured result back out in row-major order.
module mat_mul_ctrl
    import mat_acc_pkg::*;
#(
    parameter int unsigned mat_size = 2,
    parameter int unsigned dat_size = 8,
    parameter int unsigned timeout  = 256
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [dat_size-1:0]                              in_data,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [dat_size-1:0]                              out_data,
    output logic                                             mul_start,
    input  logic                                             mul_done,
    output logic [mat_size-1:0][mat_size-1:0][dat_size-1:0]  mat_A,
    output logic [mat_size-1:0][mat_size-1:0][dat_size-1:0]  mat_B,
    input  logic [mat_size-1:0][mat_size-1:0][dat_size-1:0]  mat_C,
    output logic                                             busy,
    output logic                                             err
);
    localparam int unsigned N_ELEMS = mat_size * mat_size;
    localparam int unsigned IDX_W   = idx_width(mat_size);
    localparam int unsigned RC_W    = (mat_size > 1) ? $clog2(mat_size) : 1;
    localparam int unsigned WC_W    = $clog2(timeout + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(timeout - 1);

    typedef logic [mat_size-1:0][mat_size-1:0][dat_size-1:0] mat_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx;
    logic             idx_last;
    logic             cnt_inc, cnt_clr;
    logic [RC_W-1:0]  row, col;
    mat_t             mat_a_q, mat_a_d;
    mat_t             mat_b_q, mat_b_d;
    mat_t             c_reg_q, c_reg_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic             in_hs, out_hs;
    logic             done_seen, wait_expired;

    mat_elem_cnt #(
        .n_elems (N_ELEMS),
        .idx_w   (IDX_W)
    ) u_elem_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .idx  (idx),
        .last (idx_last)
    );

    assign row   = RC_W'(elem_row(32'(idx), mat_size));
    assign col   = RC_W'(elem_col(32'(idx), mat_size));
    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    // done may still be high from the previous frame, so the first WAIT cycle never accepts it.
    assign done_seen    = mul_done && (wait_cnt_q != '0);
    assign wait_expired = (wait_cnt_q == WAIT_LAST);

    assign mat_A = mat_a_q;
    assign mat_B = mat_b_q;
    assign err   = err_q;

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD_A;
            mat_a_q    <= '0;
            mat_b_q    <= '0;
            c_reg_q    <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mat_a_q    <= mat_a_d;
            mat_b_q    <= mat_b_d;
            c_reg_q    <= c_reg_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic and element-counter control.
    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            LOAD_A: if (in_hs) begin
                cnt_inc = 1'b1;
                if (idx_last) state_d = LOAD_B;
            end
            LOAD_B: if (in_hs) begin
                cnt_inc = 1'b1;
                if (idx_last) state_d = START;
            end
            START: state_d = WAIT;
            WAIT: begin
                if (done_seen) begin
                    state_d = DRAIN;
                end else if (wait_expired) begin
                    state_d = LOAD_A;
                    cnt_clr = 1'b1;
                end
            end
            DRAIN: if (out_hs) begin
                cnt_inc = 1'b1;
                if (idx_last) state_d = LOAD_A;
            end
            default: begin
                state_d = LOAD_A;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Datapath next values: operand capture, result capture, wait counter, sticky error.
    always_comb begin
        mat_a_d    = mat_a_q;
        mat_b_d    = mat_b_q;
        c_reg_d    = c_reg_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        case (state_q)
            LOAD_A: if (in_hs) mat_a_d[row][col] = in_data;
            LOAD_B: if (in_hs) mat_b_d[row][col] = in_data;
            START:  wait_cnt_d = '0;
            WAIT: begin
                if (done_seen) begin
                    c_reg_d = mat_C;
                end else if (wait_expired) begin
                    err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from registered state only (no path from in_valid/out_ready).
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_start = 1'b0;
        out_data  = '0;
        case (state_q)
            LOAD_A, LOAD_B: in_ready = 1'b1;
            START:          mul_start = 1'b1;
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = c_reg_q[row][col];
            end
            default: ;
        endcase
        busy = (state_q != LOAD_A) || (idx != '0);
    end

endmodule

// File: tb/tb_mat_mul_ctrl.sv
// Bench for mat_mul_ctrl: a 2x2 instance for the directed frame tests and a
// 3x3 instance for the bubbled-input frame, each with a behavioural multiplier.
module tb_mat_mul_ctrl;
    localparam int DW  = 8;
    localparam int TMO = 256;

    typedef logic [1:0][1:0][DW-1:0] mat2_t;
    typedef logic [2:0][2:0][DW-1:0] mat3_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          in_valid2, in_ready2, out_valid2, out_ready2, mul_start2, mul_done2, busy2, err2;
    logic [DW-1:0] in_data2, out_data2;
    mat2_t         mat_A2, mat_B2;
    mat2_t         mat_C2 = '0;

    logic          in_valid3, in_ready3, out_valid3, out_ready3, mul_start3, mul_done3, busy3, err3;
    logic [DW-1:0] in_data3, out_data3;
    mat3_t         mat_A3, mat_B3;
    mat3_t         mat_C3 = '0;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] sb2[$];
    logic [DW-1:0] sb3[$];

    int av[9];
    int bv[9];

    mat_mul_ctrl #(.mat_size(2), .dat_size(DW), .timeout(TMO)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .mul_start(mul_start2), .mul_done(mul_done2),
        .mat_A(mat_A2), .mat_B(mat_B2), .mat_C(mat_C2),
        .busy(busy2), .err(err2)
    );

    mat_mul_ctrl #(.mat_size(3), .dat_size(DW), .timeout(TMO)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .mul_start(mul_start3), .mul_done(mul_done3),
        .mat_A(mat_A3), .mat_B(mat_B3), .mat_C(mat_C3),
        .busy(busy3), .err(err3)
    );

    function automatic mat2_t mul2(input mat2_t a, input mat2_t b);
        mat2_t res;
        int acc;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                acc = 0;
                for (int k = 0; k < 2; k++) acc += int'(a[r][k]) * int'(b[k][c]);
                res[r][c] = acc[DW-1:0];
            end
        return res;
    endfunction

    function automatic mat3_t mul3(input mat3_t a, input mat3_t b);
        mat3_t res;
        int acc;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                acc = 0;
                for (int k = 0; k < 3; k++) acc += int'(a[r][k]) * int'(b[k][c]);
                res[r][c] = acc[DW-1:0];
            end
        return res;
    endfunction

    // Multiplier models: done is a level that drops one cycle after start is seen
    // and rises again with a fresh result a few cycles later (unless hung).
    logic start_d2 = 1'b0, mdl_done2 = 1'b0, force_done2 = 1'b0, hang2 = 1'b0;
    int   mcnt2 = 0;
    int   starts2 = 0;
    assign mul_done2 = mdl_done2 | force_done2;
    always @(posedge clk) begin
        start_d2 <= mul_start2;
        if (mul_start2) starts2 <= starts2 + 1;
        if (start_d2) begin
            mdl_done2 <= 1'b0;
            mcnt2     <= 3;
        end else if (mcnt2 > 0) begin
            mcnt2 <= mcnt2 - 1;
            if (mcnt2 == 1 && !hang2) begin
                mdl_done2 <= 1'b1;
                mat_C2    <= mul2(mat_A2, mat_B2);
            end
        end
    end

    logic start_d3 = 1'b0, mdl_done3 = 1'b0;
    int   mcnt3 = 0;
    int   starts3 = 0;
    assign mul_done3 = mdl_done3;
    always @(posedge clk) begin
        start_d3 <= mul_start3;
        if (mul_start3) starts3 <= starts3 + 1;
        if (start_d3) begin
            mdl_done3 <= 1'b0;
            mcnt3     <= 2;
        end else if (mcnt3 > 0) begin
            mcnt3 <= mcnt3 - 1;
            if (mcnt3 == 1) begin
                mdl_done3 <= 1'b1;
                mat_C3    <= mul3(mat_A3, mat_B3);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one element; in_ready must already be high in a load state.
    task automatic send(input int n, input logic [DW-1:0] d);
        int guard;
        logic rdy;
        guard = 0;
        if (n == 2) begin in_valid2 = 1'b1; in_data2 = d; end
        else        begin in_valid3 = 1'b1; in_data3 = d; end
        rdy = (n == 2) ? in_ready2 : in_ready3;
        check("in_ready", 64'(rdy), 64'(1));
        while (!rdy && guard < 50) begin
            tick();
            guard++;
            rdy = (n == 2) ? in_ready2 : in_ready3;
        end
        tick();
        if (n == 2) in_valid2 = 1'b0;
        else        in_valid3 = 1'b0;
    endtask

    // Stream A then B (row-major) and, if asked, push the expected C onto the scoreboard.
    task automatic load(input int n, input int a[9], input int b[9], input bit push, input bit bub);
        int acc;
        for (int i = 0; i < n * n; i++) begin
            if (bub) repeat ($urandom_range(0, 2)) tick();
            send(n, DW'(a[i]));
        end
        for (int i = 0; i < n * n; i++) begin
            if (bub) repeat ($urandom_range(0, 2)) tick();
            send(n, DW'(b[i]));
        end
        if (push) begin
            for (int r = 0; r < n; r++)
                for (int c = 0; c < n; c++) begin
                    acc = 0;
                    for (int k = 0; k < n; k++) acc += a[r * n + k] * b[k * n + c];
                    if (n == 2) sb2.push_back(acc[DW-1:0]);
                    else        sb3.push_back(acc[DW-1:0]);
                end
        end
    endtask

    // Collect n*n results, optionally with out_ready pattern 1,0,0,1,0,0,... on valid cycles.
    task automatic drain(input int n, input bit bp);
        int got, cyc, vcnt, sz;
        logic [DW-1:0] held, exp, od;
        logic ov, rdy;
        bit stalled;
        got = 0; cyc = 0; vcnt = 0; stalled = 0; held = '0;
        while (got < n * n && cyc < 1000) begin
            ov  = (n == 2) ? out_valid2 : out_valid3;
            od  = (n == 2) ? out_data2  : out_data3;
            rdy = !bp || (vcnt % 3 == 0);
            if (n == 2) out_ready2 = rdy;
            else        out_ready3 = rdy;
            if (ov) begin
                if (stalled) check("stall_hold", 64'(od), 64'(held));
                if (rdy) begin
                    sz = (n == 2) ? sb2.size() : sb3.size();
                    check("sb_has_entry", 64'(sz > 0), 64'(1));
                    exp = '0;
                    if (sz > 0) exp = (n == 2) ? sb2.pop_front() : sb3.pop_front();
                    check("out_data", 64'(od), 64'(exp));
                    got++;
                    stalled = 0;
                end else begin
                    held    = od;
                    stalled = 1;
                end
                vcnt++;
            end
            tick();
            cyc++;
        end
        if (n == 2) out_ready2 = 1'b0;
        else        out_ready3 = 1'b0;
        check("drain_count", 64'(got), 64'(n * n));
        check("post_out_valid", 64'((n == 2) ? out_valid2 : out_valid3), 64'(0));
        check("post_busy", 64'((n == 2) ? busy2 : busy3), 64'(0));
        check("post_in_ready", 64'((n == 2) ? in_ready2 : in_ready3), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ov_cnt;
        rst = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
        in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        check("rst_in_ready", 64'(in_ready2), 64'(1));
        check("rst_out_valid", 64'(out_valid2), 64'(0));
        check("rst_out_data", 64'(out_data2), 64'(0));
        check("rst_mul_start", 64'(mul_start2), 64'(0));
        check("rst_busy", 64'(busy2), 64'(0));
        check("rst_err", 64'(err2), 64'(0));
        check("rst_mat_A", 64'(mat_A2), 64'(0));
        check("rst_mat_B", 64'(mat_B2), 64'(0));
        rst = 1'b0;
        tick();

        // basic 2x2 frame
        av = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
        bv = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
        load(2, av, bv, 1'b1, 1'b0);
        check("start_pulse", 64'(mul_start2), 64'(1));
        check("busy_in_start", 64'(busy2), 64'(1));
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                check("mat_A_elem", 64'(mat_A2[r][c]), 64'(av[r * 2 + c]));
                check("mat_B_elem", 64'(mat_B2[r][c]), 64'(bv[r * 2 + c]));
            end
        tick();
        check("start_one_cycle", 64'(mul_start2), 64'(0));
        check("wait_in_ready", 64'(in_ready2), 64'(0));
        drain(2, 1'b0);
        check("start_count1", 64'(starts2), 64'(1));

        // back-pressure frame; done is still high from the previous frame
        av = '{2, 0, 1, 3, 0, 0, 0, 0, 0};
        bv = '{4, 5, 6, 7, 0, 0, 0, 0, 0};
        load(2, av, bv, 1'b1, 1'b0);
        tick();
        check("stale_done_wait0", 64'(out_valid2), 64'(0));
        drain(2, 1'b1);
        check("start_count2", 64'(starts2), 64'(2));

        // full-width element values
        av = '{165, 255, 128, 1, 0, 0, 0, 0, 0};
        bv = '{2, 254, 127, 3, 0, 0, 0, 0, 0};
        load(2, av, bv, 1'b1, 1'b0);
        drain(2, 1'b0);

        // done pulse while idle is ignored
        force_done2 = 1'b1;
        tick();
        force_done2 = 1'b0;
        tick();
        check("idle_done_out_valid", 64'(out_valid2), 64'(0));
        check("idle_done_busy", 64'(busy2), 64'(0));

        // timeout: multiplier never completes
        hang2 = 1'b1;
        av = '{9, 8, 7, 6, 0, 0, 0, 0, 0};
        bv = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
        load(2, av, bv, 1'b0, 1'b0);
        tick();
        ov_cnt = 0;
        for (int k = 1; k <= TMO; k++) begin
            tick();
            if (out_valid2) ov_cnt++;
            if (k == TMO - 1) check("err_before_timeout", 64'(err2), 64'(0));
        end
        check("err_at_timeout", 64'(err2), 64'(1));
        check("timeout_in_ready", 64'(in_ready2), 64'(1));
        check("timeout_busy", 64'(busy2), 64'(0));
        check("timeout_no_out_valid", 64'(ov_cnt), 64'(0));
        hang2 = 1'b0;
        tick();

        // a normal frame afterwards works and err stays set
        av = '{1, 1, 2, 3, 0, 0, 0, 0, 0};
        bv = '{4, 0, 5, 6, 0, 0, 0, 0, 0};
        load(2, av, bv, 1'b1, 1'b0);
        drain(2, 1'b0);
        check("err_sticky", 64'(err2), 64'(1));

        // reset mid-load discards the partial frame and clears err
        send(2, 8'd9);
        send(2, 8'd10);
        send(2, 8'd11);
        check("midload_busy", 64'(busy2), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 64'(busy2), 64'(0));
        check("midrst_mat_A", 64'(mat_A2), 64'(0));
        check("midrst_in_ready", 64'(in_ready2), 64'(1));
        check("midrst_err", 64'(err2), 64'(0));
        check("midrst_out_valid", 64'(out_valid2), 64'(0));
        av = '{3, 1, 4, 1, 0, 0, 0, 0, 0};
        bv = '{5, 9, 2, 6, 0, 0, 0, 0, 0};
        load(2, av, bv, 1'b1, 1'b0);
        drain(2, 1'b0);

        // 3x3 frame with random input bubbles
        for (int i = 0; i < 9; i++) begin
            av[i] = int'($urandom_range(0, 255));
            bv[i] = int'($urandom_range(0, 255));
        end
        load(3, av, bv, 1'b1, 1'b1);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                check("n3_mat_A_elem", 64'(mat_A3[r][c]), 64'(av[r * 3 + c]));
                check("n3_mat_B_elem", 64'(mat_B3[r][c]), 64'(bv[r * 3 + c]));
            end
        drain(3, 1'b0);
        check("n3_start_count", 64'(starts3), 64'(1));

        check("sb2_empty", 64'(sb2.size()), 64'(0));
        check("sb3_empty", 64'(sb3.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mat_mul_ctrl.md
# mat_mul_ctrl

Streaming front-end that feeds the 2-D matrix multiplier and drains its result. Accepts operand elements over a valid/ready input stream, assembles mat_A and mat_B, issues a single-cycle start to the multiplier, waits for done, and returns mat_C over a valid/ready output stream. Sits between the bus-side FIFO/DMA path and the multiplier instance in the accelerator.

## Interface
- mat_size, 2, matrix dimension N (N×N operands and result)
- dat_size, 8, element width in bits
- timeout, 256, max cycles in WAIT before the error path is taken
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input element valid
- in_ready  out  1  controller can accept an input element
- in_data  in  dat_size  input element, row-major, all A elements then all B elements
- out_valid  out  1  result element valid
- out_ready  in  1  downstream accepts result element
- out_data  out  dat_size  result element, row-major
- mul_start  out  1  start pulse to multiplier
- mul_done  in  1  multiplier done (level)
- mat_A  out  dat_size × [N][N]  operand A to multiplier
- mat_B  out  dat_size × [N][N]  operand B to multiplier
- mat_C  in  dat_size × [N][N]  result from multiplier
- busy  out  1  frame in progress
- err  out  1  sticky timeout flag

## Operation
- States: LOAD_A, LOAD_B, START, WAIT, DRAIN. Reset state LOAD_A.
- Element index idx, 0..N*N-1, maps to row idx/N, col idx%N.
- LOAD_A: in_ready=1; on in_valid&&in_ready write in_data to mat_A[row][col], idx++. At idx=N*N-1 with handshake: idx←0, go LOAD_B.
- LOAD_B: same into mat_B; at last element go START.
- START: mul_start=1 for exactly this one cycle; go WAIT, clear wait counter.
- WAIT: in_ready=0. mul_done is ignored in the first WAIT cycle (multiplier done is a level and may still be high from the previous frame). From the second WAIT cycle on, mul_done=1 → capture mat_C into internal c_reg, go DRAIN. If the wait counter reaches timeout first → err←1, go LOAD_A with idx=0.
- DRAIN: out_valid=1, out_data=c_reg[row][col]. On out_valid&&out_ready: idx++. After the last element handshakes: idx←0, go LOAD_A.
- busy = (state≠LOAD_A) || (idx≠0).
- mat_A/mat_B hold their last written values until overwritten by the next frame. They are not cleared between frames.
- err clears only on rst.
- No arithmetic in this block. Elements pass through unmodified at full dat_size width.

## Timing
- Reset values: in_ready=1 (state LOAD_A), out_valid=0, out_data=0, mul_start=0, busy=0, err=0, mat_A/mat_B all zero, c_reg zero, idx=0.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid or out_ready.
- Minimum frame latency, from last B handshake to first out_valid: START (1) + WAIT (≥2) cycles. out_valid rises the cycle after mul_done is sampled.
- Output stream: out_data is stable while out_valid=1 && out_ready=0. With out_ready held high, one element per cycle.
- Input stream: one element per cycle with in_valid held high. LOAD_A→LOAD_B has no bubble.
- rst mid-frame, in any state: all state returns to reset values next cycle; the partial frame is discarded and no output is produced for it.
- A mul_done pulse outside WAIT is ignored.

## Structure
- Shared package mat_acc_pkg holds:
  - the state enum (LOAD_A…DRAIN);
  - idx width constant $clog2(mat_size*mat_size);
  - the element-index-to-(row,col) helper functions.
- One sub-module is natural: mat_elem_cnt. It is the wrapping 0..N*N-1 index counter with inc, clr and last outputs, reused for both load and drain.

## Test plan
- Basic 2×2: stream A=1,2,3,4 and B=5,6,7,8; multiplier model returns C=[[19,22],[43,50]] → mul_start high exactly 1 cycle; out_data sequence 19,22,43,50; busy falls after the last handshake.
- Back-pressure: same frame with out_ready toggled 1,0,0,1,… → every element held stable while stalled; exactly 4 handshakes, order preserved.
- Stale done: mul_done left high from the previous frame → new C is not captured in the first WAIT cycle; capture occurs on the multiplier's fresh done.
- Timeout: mul_done tied 0 → err=1 exactly timeout cycles after entering WAIT; state returns to LOAD_A; out_valid never asserts; err stays 1 until rst.
- Reset mid-load: rst asserted after 3 A elements → next cycle idx=0, mat_A zero, busy=0; a subsequent full frame produces the correct C.
- Input gaps: in_valid with random bubbles, N=3 parameterization → 9+9 elements captured in row-major order; result matches the reference model.
